pi1b_to_wb4_wbuf: RTL and testbench

- PI1 slave to Wishbone B4 pipelined master bridge with a posted-write buffer, a generalised byte-lane address map, error/timeout handling and atomic read-then-write (PIRWOP) support.
- Sits between a pi1 interconnect port and a wb4 peripheral or memory.
- PI1 writes retire into a FIFO immediately. Reads and read-writes drain the FIFO first, so ordering is preserved.

---
 rtl/pi1b_to_wb4_wbuf.sv | 256 +++++++++++++++++++++++++
 tb/tb_pi1b_to_wb4_wbuf.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi1b_to_wb4_wbuf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pi1b_to_wb4_wbuf
// Description : PI1 slave to Wishbone B4 pipelined master bridge.
//               PI1 writes are posted into a small FIFO and drained in order.
//               Reads and read-then-write (RW) requests wait until the FIFO
//               has drained, so ordering is preserved. A wb4 cycle that ends
//               in err or timeout pulses err_o. Read data then reads as all
//               ones, an RW skips its write phase, and a posted write is
//               dropped.
// Ports       : clk_i, rst_i            clock, synchronous active-high reset
//               pi1_op_i/addr/data/sel  PI1 request (00 NOOP 01 WR 10 RD 11 RW)
//               pi1_data_o, pi1_rdy_o   PI1 read data (DONE cycle only), ready
//               wb4_* outputs           wb4 pipelined master request
//               wb4_stall/ack/err/data  wb4 slave response
//               err_o                   one-cycle pulse per failed wb4 cycle
// Revision    : 1.0 - initial release
// ============================================================================
module pi1b_to_wb4_wbuf #(
    parameter int ARCHBITSZ  = 32,
    parameter int WRBUFDEPTH = 4,
    parameter int TIMEOUT    = 1024,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    output logic                   wb4_cyc_o,
    output logic                   wb4_stb_o,
    output logic                   wb4_we_o,
    output logic [ARCHBITSZ-1:0]   wb4_addr_o,
    output logic [ARCHBITSZ-1:0]   wb4_data_o,
    output logic [ARCHBITSZ/8-1:0] wb4_sel_o,
    input  logic                   wb4_stall_i,
    input  logic                   wb4_ack_i,
    input  logic                   wb4_err_i,
    input  logic [ARCHBITSZ-1:0]   wb4_data_i,
    output logic                   err_o
);

    localparam int c_SELW = ARCHBITSZ / 8;
    localparam int c_OFFW = $clog2(c_SELW);
    localparam int c_PTRW = $clog2(WRBUFDEPTH);
    localparam int c_CNTW = c_PTRW + 1;
    localparam int c_TMOW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] c_OP_NOOP = 2'b00;
    localparam logic [1:0] c_OP_WR   = 2'b01;
    localparam logic [1:0] c_OP_RW   = 2'b11;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_DRAIN  = 3'd1;
    localparam logic [2:0] c_ST_RDREQ  = 3'd2;
    localparam logic [2:0] c_ST_RDWAIT = 3'd3;
    localparam logic [2:0] c_ST_WRREQ  = 3'd4;
    localparam logic [2:0] c_ST_WRWAIT = 3'd5;
    localparam logic [2:0] c_ST_DONE   = 3'd6;

    // Byte offset of the lowest enabled lane; zero when no lane is enabled.
    function automatic logic [c_OFFW-1:0] f_low_lane(input logic [c_SELW-1:0] sel);
        logic [c_OFFW-1:0] off;
        off = '0;
        for (int i = c_SELW - 1; i >= 0; i--) begin
            if (sel[i]) off = c_OFFW'(i);
        end
        return off;
    endfunction

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_cyc, r_stb, r_we, r_err, r_is_rw, r_full;
    logic [ARCHBITSZ-1:0] r_addr, r_wdata, r_rdata, r_req_data;
    logic [c_SELW-1:0]    r_sel, r_req_sel;
    logic [ADDRBITSZ-1:0] r_req_addr;
    logic [c_TMOW-1:0]    r_tmo;

    logic [ADDRBITSZ-1:0] r_fifo_addr [WRBUFDEPTH];
    logic [ARCHBITSZ-1:0] r_fifo_data [WRBUFDEPTH];
    logic [c_SELW-1:0]    r_fifo_sel  [WRBUFDEPTH];
    logic [c_PTRW-1:0]    r_wptr, r_rptr;
    logic [c_CNTW-1:0]    r_count;
    logic [c_CNTW-1:0]    w_count_nxt;

    logic w_rdy, w_accept, w_push, w_rd_accept, w_empty;
    logic w_tmo, w_end, w_fail, w_drain;
    logic w_pop, w_rd_start, w_rw_start, w_close, w_rd_latch;

    assign w_empty     = (r_count == '0);
    assign w_rdy       = !rst_i && !r_full && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_accept    = w_rdy && (pi1_op_i != c_OP_NOOP);
    assign w_push      = w_accept && (pi1_op_i == c_OP_WR);
    assign w_rd_accept = w_accept && pi1_op_i[1];

    generate
        if (TIMEOUT > 0) begin : g_tmo_on
            assign w_tmo = r_cyc && (r_tmo == c_TMOW'(TIMEOUT));
        end else begin : g_tmo_off
            assign w_tmo = 1'b0;
        end
    endgenerate

    // err wins over a simultaneous ack.
    assign w_end  = r_cyc && (wb4_ack_i || wb4_err_i || w_tmo);
    assign w_fail = r_cyc && (wb4_err_i || w_tmo);
    // The next posted write may go out when the bus is idle or the current
    // write is finishing this cycle (back-to-back, cyc stays high).
    assign w_drain = !w_empty && (!r_cyc || w_end);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rd_start  = 1'b0;
        w_rw_start  = 1'b0;
        w_close     = 1'b0;
        w_rd_latch  = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DRAIN: begin
                if (w_drain)    w_pop   = 1'b1;
                else if (w_end) w_close = 1'b1;
                if (r_state == c_ST_IDLE) begin
                    if (w_rd_accept) w_state_nxt = c_ST_DRAIN;
                end else if (w_empty && !r_cyc) begin
                    w_rd_start  = 1'b1;
                    w_state_nxt = c_ST_RDREQ;
                end
            end
            c_ST_RDREQ, c_ST_RDWAIT: begin
                if (w_end) begin
                    w_rd_latch = 1'b1;
                    if (!w_fail && r_is_rw) begin
                        w_rw_start  = 1'b1;
                        w_state_nxt = c_ST_WRREQ;
                    end else begin
                        w_close     = 1'b1;
                        w_state_nxt = c_ST_DONE;
                    end
                end else if ((r_state == c_ST_RDREQ) && !wb4_stall_i) begin
                    w_state_nxt = c_ST_RDWAIT;
                end
            end
            c_ST_WRREQ, c_ST_WRWAIT: begin
                if (w_end) begin
                    w_close     = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end else if ((r_state == c_ST_WRREQ) && !wb4_stall_i) begin
                    w_state_nxt = c_ST_WRWAIT;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = w_rd_accept ? c_ST_DRAIN : c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_count_nxt = r_count + c_CNTW'(w_push) - c_CNTW'(w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= pi1_addr_i;
            r_fifo_data[r_wptr] <= pi1_data_i;
            r_fifo_sel[r_wptr]  <= pi1_sel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_is_rw    <= 1'b0;
            r_full     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_sel      <= '0;
            r_rdata    <= '0;
            r_req_addr <= '0;
            r_req_sel  <= '0;
            r_req_data <= '0;
            r_tmo      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_err <= w_fail;
            if (w_rd_accept) begin
                r_req_addr <= pi1_addr_i;
                r_req_sel  <= pi1_sel_i;
                r_req_data <= pi1_data_i;
                r_is_rw    <= (pi1_op_i == c_OP_RW);
            end
            if (w_rd_latch) r_rdata <= w_fail ? '1 : wb4_data_i;

            if (w_pop) begin
                r_cyc   <= 1'b1;
                r_stb   <= 1'b1;
                r_we    <= 1'b1;
                r_addr  <= {r_fifo_addr[r_rptr], f_low_lane(r_fifo_sel[r_rptr])};
                r_wdata <= r_fifo_data[r_rptr];
                r_sel   <= r_fifo_sel[r_rptr];
            end else if (w_rd_start) begin
                r_cyc  <= 1'b1;
                r_stb  <= 1'b1;
                r_we   <= 1'b0;
                r_addr <= {r_req_addr, f_low_lane(r_req_sel)};
                r_sel  <= r_req_sel;
            end else if (w_rw_start) begin
                // Write phase of the locked RW: cyc is already high.
                r_stb   <= 1'b1;
                r_we    <= 1'b1;
                r_wdata <= r_req_data;
            end else if (w_close) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
                r_we  <= 1'b0;
            end else if (r_stb && !wb4_stall_i) begin
                r_stb <= 1'b0;
            end

            // Counter starts at 1 on issue so cyc is high for exactly
            // TIMEOUT cycles before a timeout closes it.
            if (w_pop || w_rd_start || w_rw_start) r_tmo <= c_TMOW'(1);
            else if (w_end)                        r_tmo <= '0;
            else if (r_cyc)                        r_tmo <= r_tmo + 1'b1;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNTW'(WRBUFDEPTH));
        end
    end

    assign pi1_rdy_o  = w_rdy;
    assign pi1_data_o = (r_state == c_ST_DONE) ? r_rdata : '0;
    assign wb4_cyc_o  = r_cyc;
    assign wb4_stb_o  = r_stb;
    assign wb4_we_o   = r_we;
    assign wb4_addr_o = r_addr;
    assign wb4_data_o = r_wdata;
    assign wb4_sel_o  = r_sel;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pi1b_to_wb4_wbuf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pi1b_to_wb4_wbuf
// Description : Directed self-checking bench for pi1b_to_wb4_wbuf with a
//               small wb4 memory slave (registered ack, programmable stall,
//               err and no-response modes) and a request log.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi1b_to_wb4_wbuf;

    localparam logic [1:0] c_NOOP = 2'b00;
    localparam logic [1:0] c_WR   = 2'b01;
    localparam logic [1:0] c_RD   = 2'b10;
    localparam logic [1:0] c_RW   = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op = c_NOOP;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;
    logic [31:0] pdata;
    logic        rdy;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_dout;
    logic [3:0]  wb_sel;
    logic        wb_stall;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pi1b_to_wb4_wbuf #(.ARCHBITSZ(32), .WRBUFDEPTH(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .pi1_op_i(op), .pi1_addr_i(addr), .pi1_data_i(wdata), .pi1_data_o(pdata),
        .pi1_sel_i(sel), .pi1_rdy_o(rdy),
        .wb4_cyc_o(wb_cyc), .wb4_stb_o(wb_stb), .wb4_we_o(wb_we),
        .wb4_addr_o(wb_addr), .wb4_data_o(wb_dout), .wb4_sel_o(wb_sel),
        .wb4_stall_i(wb_stall), .wb4_ack_i(s_ack), .wb4_err_i(s_err),
        .wb4_data_i(s_rdata), .err_o(err)
    );

    // ---------------- wb4 slave model ----------------
    logic        hold_stall = 1'b0;
    logic        err_mode   = 1'b0;
    logic        no_resp    = 1'b0;
    int          stall_cfg  = 0;
    int          stall_seen = 0;
    logic [31:0] mem [256];
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    logic [3:0]  log_sel  [64];
    logic        log_we   [64];
    int          log_n = 0;

    assign wb_stall = hold_stall || (wb_cyc && wb_stb && (stall_seen < stall_cfg));

    always @(posedge clk) begin
        s_ack <= 1'b0;
        s_err <= 1'b0;
        if (wb_cyc && wb_stb) begin
            if (wb_stall) stall_seen <= stall_seen + 1;
        end else begin
            stall_seen <= 0;
        end
        if (wb_cyc && wb_stb && !wb_stall) begin
            if (log_n < 64) begin
                log_addr[log_n] <= wb_addr;
                log_data[log_n] <= wb_dout;
                log_sel[log_n]  <= wb_sel;
                log_we[log_n]   <= wb_we;
            end
            log_n <= log_n + 1;
            if (!no_resp) begin
                if (err_mode) begin
                    s_err <= 1'b1;
                end else begin
                    s_ack <= 1'b1;
                    if (wb_we) begin
                        for (int b = 0; b < 4; b++)
                            if (wb_sel[b]) mem[wb_addr[9:2]][8*b +: 8] <= wb_dout[8*b +: 8];
                    end else begin
                        s_rdata <= mem[wb_addr[9:2]];
                    end
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic cyc_q = 1'b0, err_q = 1'b0;
    int   cyc_rises = 0, cyc_run = 0, cyc_last = 0;
    int   stb_run = 0, stb_last = 0;
    int   err_cnt = 0, err_long = 0;

    always @(posedge clk) begin
        cyc_q <= wb_cyc;
        err_q <= err;
        if (wb_cyc && !cyc_q) cyc_rises <= cyc_rises + 1;
        if (wb_cyc) cyc_run <= cyc_run + 1;
        else begin
            if (cyc_run != 0) cyc_last <= cyc_run;
            cyc_run <= 0;
        end
        if (wb_stb) stb_run <= stb_run + 1;
        else begin
            if (stb_run != 0) stb_last <= stb_run;
            stb_run <= 0;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (err && err_q) err_long <= err_long + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the edge on which rdy is high.
    task automatic req(input logic [1:0] o, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int waited);
        waited = 0;
        op = o; addr = a; wdata = d; sel = s;
        while (!rdy && waited < 200) begin
            tick();
            waited++;
        end
        if (!rdy) chk("req_accept_timeout", 64'(waited), 64'(0));
        tick();
        op = c_NOOP;
    endtask

    // Edges until rdy returns (DONE cycle after a read).
    task automatic wait_rdy(output int n);
        n = 0;
        while (!rdy && n < 100) begin
            tick();
            n++;
        end
        if (!rdy) chk("wait_rdy_timeout", 64'(n), 64'(0));
    endtask

    task automatic wait_log(input int target);
        int n;
        n = 0;
        while (log_n < target && n < 100) begin
            tick();
            n++;
        end
        if (log_n < target) chk("wait_log_timeout", 64'(log_n), 64'(target));
        repeat (3) tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w, acc, base, r0, e0, n;

        // Reset state
        repeat (3) tick();
        chk("rst_rdy", 64'(rdy), 64'(0));
        chk("rst_cyc", 64'(wb_cyc), 64'(0));
        chk("rst_stb", 64'(wb_stb), 64'(0));
        chk("rst_we", 64'(wb_we), 64'(0));
        chk("rst_addr", 64'(wb_addr), 64'(0));
        chk("rst_pdata", 64'(pdata), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", 64'(rdy), 64'(1));

        // Posted writes: first one goes out and stalls, next four fill the FIFO.
        hold_stall = 1'b1;
        base = log_n;
        r0 = cyc_rises;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            req(c_WR, 30'h10 + 30'(i), 32'hA0 + 32'(i), 4'hF, w);
            acc += w;
        end
        chk("fill_no_wait", 64'(acc), 64'(0));
        chk("fill_full_rdy", 64'(rdy), 64'(0));
        hold_stall = 1'b0;
        wait_log(base + 5);
        for (int i = 0; i < 5; i++) begin
            chk("fill_order_addr", 64'(log_addr[base + i]), 64'(32'h40 + 32'(4 * i)));
            chk("fill_order_data", 64'(log_data[base + i]), 64'(32'hA0 + 32'(i)));
        end
        chk("fill_one_cyc_run", 64'(cyc_rises - r0), 64'(1));
        chk("fill_rdy_back", 64'(rdy), 64'(1));

        // Read-after-write
        base = log_n;
        req(c_WR, 30'h20, 32'hDEADBEEF, 4'hF, w);
        req(c_RD, 30'h20, 32'h0, 4'hF, w);
        wait_rdy(n);
        chk("raw_data", 64'(pdata), 64'(32'hDEADBEEF));
        chk("raw_first_is_write", 64'(log_we[base]), 64'(1));
        chk("raw_then_read", 64'(log_we[base + 1]), 64'(0));
        chk("raw_read_addr", 64'(log_addr[base + 1]), 64'(32'h80));
        tick();
        chk("raw_pdata_cleared", 64'(pdata), 64'(0));

        // Latency with an empty FIFO: accept edge, then DRAIN, RDREQ, RDWAIT -> DONE
        req(c_RD, 30'h20, 32'h0, 4'hF, w);
        wait_rdy(n);
        chk("rd_latency", 64'(n), 64'(3));
        chk("rd_data", 64'(pdata), 64'(32'hDEADBEEF));

        // Atomic RW
        base = log_n;
        req(c_WR, 30'h30, 32'h11, 4'hF, w);
        wait_log(base + 1);
        r0 = cyc_rises;
        req(c_RW, 30'h30, 32'h22, 4'hF, w);
        wait_rdy(n);
        chk("rw_old_data", 64'(pdata), 64'(32'h11));
        tick();
        chk("rw_cyc_continuous", 64'(cyc_rises - r0), 64'(1));
        req(c_RD, 30'h30, 32'h0, 4'hF, w);
        wait_rdy(n);
        chk("rw_new_data", 64'(pdata), 64'(32'h22));

        // Byte lane address and stall
        base = log_n;
        req(c_WR, 30'h5, 32'h12345678, 4'hF, w);
        wait_log(base + 1);
        stall_cfg = 3;
        base = log_n;
        req(c_RD, 30'h5, 32'h0, 4'b0100, w);
        wait_rdy(n);
        chk("lane_data", 64'(pdata), 64'(32'h12345678));
        chk("lane_addr", 64'(log_addr[base]), 64'(32'h16));
        chk("lane_sel", 64'(log_sel[base]), 64'(4'b0100));
        tick();
        chk("lane_stb_len", 64'(stb_last), 64'(4));
        stall_cfg = 0;

        // Error on read
        e0 = err_cnt;
        err_mode = 1'b1;
        req(c_RD, 30'h7, 32'h0, 4'hF, w);
        wait_rdy(n);
        chk("err_rd_data", 64'(pdata), 64'(32'hFFFFFFFF));
        repeat (2) tick();
        err_mode = 1'b0;
        chk("err_rd_pulse", 64'(err_cnt - e0), 64'(1));

        // Errored posted write is dropped
        base = log_n;
        req(c_WR, 30'h8, 32'h66, 4'hF, w);
        wait_log(base + 1);
        e0 = err_cnt;
        err_mode = 1'b1;
        req(c_WR, 30'h8, 32'h55, 4'hF, w);
        n = 0;
        while (err_cnt == e0 && n < 50) begin
            tick();
            n++;
        end
        err_mode = 1'b0;
        chk("err_wr_pulse", 64'(err_cnt - e0), 64'(1));
        req(c_RD, 30'h8, 32'h0, 4'hF, w);
        wait_rdy(n);
        chk("err_wr_dropped", 64'(pdata), 64'(32'h66));

        // Timeout (TIMEOUT=8)
        e0 = err_cnt;
        no_resp = 1'b1;
        req(c_RD, 30'h9, 32'h0, 4'hF, w);
        wait_rdy(n);
        chk("tmo_data", 64'(pdata), 64'(32'hFFFFFFFF));
        repeat (2) tick();
        no_resp = 1'b0;
        chk("tmo_cyc_len", 64'(cyc_last), 64'(8));
        chk("tmo_pulse", 64'(err_cnt - e0), 64'(1));
        chk("err_single_cycle", 64'(err_long), 64'(0));

        // Reset with one write in flight and two queued
        hold_stall = 1'b1;
        base = log_n;
        for (int i = 0; i < 3; i++) req(c_WR, 30'h40 + 30'(i), 32'hC0 + 32'(i), 4'hF, w);
        chk("mid_cyc_active", 64'(wb_cyc), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", 64'(rdy), 64'(0));
        tick();
        chk("mid_rst_cyc", 64'(wb_cyc), 64'(0));
        chk("mid_rst_stb", 64'(wb_stb), 64'(0));
        rst = 1'b0;
        hold_stall = 1'b0;
        tick();
        chk("mid_rst_rdy_back", 64'(rdy), 64'(1));
        repeat (10) tick();
        chk("mid_rst_no_stale", 64'(log_n), 64'(base));
        chk("mid_rst_bus_idle", 64'(wb_cyc), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
